pll_reset_sequencer: RTL and testbench
======================================

// Module: pll_reset_sequencer
//
// PURPOSE
//   Power-up and lock-loss reset controller for the system PLL. Runs on the free-running
//   50 MHz reference clock and drives the PLL's rst input. Watches the PLL locked output and
//   releases the downstream system reset only after lock has been continuously stable.
//   Re-sequences on lock loss, on lock timeout, or on a software request.
//
// PARAMETERS
//   PLL_RST_CYCLES  16     cycles pll_rst is held high per reset attempt (>=1)
//   LOCK_TIMEOUT    50000  max cycles in WAIT_LOCK before retrying PLL reset (1 ms @ 50 MHz)
//   STABLE_CYCLES   1024   consecutive locked cycles required before sys_reset is released
//   SYNC_STAGES     2      flop stages synchronizing pll_locked into refclk domain (>=2)
//
// PORTS
//   refclk         in   1  reference clock, free-running, valid before PLL lock
//   rst            in   1  asynchronous active-high reset
//   pll_locked     in   1  PLL locked output, asynchronous to refclk
//   sw_reset_req   in   1  synchronous single-cycle request to re-sequence
//   pll_rst        out  1  reset to PLL, active-high
//   sys_reset      out  1  reset to downstream logic, active-high
//   ready          out  1  high in RUN (equivalent to ~sys_reset)
//   state          out  2  current state: 0=PLL_RST 1=WAIT_LOCK 2=STABLE 3=RUN
//   retry_count    out  4  lock-timeout retries, saturates at 15, cleared only by rst
//   lock_loss_cnt  out  8  RUN-state lock losses (see CONFIGURATION)
//
// BEHAVIOUR
//   - rst asserted (async): pll_rst=1, sys_reset=1, ready=0, state=PLL_RST, cycle counter=0,
//     retry_count=0, lock_loss_cnt=0, sync chain=0. All outputs registered.
//   - locked_s = pll_locked after SYNC_STAGES flops; all decisions use locked_s only.
//   - One shared cycle counter, width $clog2(max(PLL_RST_CYCLES,LOCK_TIMEOUT,STABLE_CYCLES)+1);
//     cleared on every state transition.
//   - PLL_RST: pll_rst=1, sys_reset=1. After PLL_RST_CYCLES cycles -> WAIT_LOCK;
//     pll_rst=0 from the first WAIT_LOCK cycle.
//   - WAIT_LOCK: locked_s=1 -> STABLE. If the counter reaches LOCK_TIMEOUT-1 with locked_s=0
//     -> PLL_RST and retry_count+1 (saturating). A coincident lock and timeout takes STABLE.
//   - STABLE: locked_s=0 -> WAIT_LOCK (no PLL reset, no retry increment).
//     STABLE_CYCLES consecutive locked_s=1 cycles -> RUN; sys_reset=0 and ready=1 on the
//     same edge that enters RUN.
//   - RUN: locked_s=0 -> PLL_RST; sys_reset=1 and ready=0 on that edge; lock_loss_cnt+1.
//   - sw_reset_req=1 in any state -> PLL_RST next edge, highest priority over all other
//     transitions. It does not touch retry_count or lock_loss_cnt.
//   - Worst-case latency pll_locked rise -> sys_reset fall = SYNC_STAGES + STABLE_CYCLES + 1.
//   - rst asserted mid-sequence aborts immediately to reset values. Release is synchronous
//     to refclk, and sequencing restarts in PLL_RST.
//
// CONFIGURATION
//   LOCK_LOSS_CNT_EN defined: lock_loss_cnt is an 8-bit counter, saturating at 255 and
//     cleared only by rst, incremented once per RUN->PLL_RST transition caused by locked_s=0.
//     A transition caused by sw_reset_req does not increment it.
//   LOCK_LOSS_CNT_EN undefined: no counter logic is synthesized; lock_loss_cnt tied to 8'd0.
//
// TESTING  (PLL_RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, SYNC_STAGES=2)
//   1 Power-up: release rst, raise pll_locked at cycle 10 -> pll_rst high cycles 0-3,
//     sys_reset falls at cycle 10+2+8+1=21, state=3.
//   2 Timeout: hold pll_locked=0 -> pll_rst re-pulses every 24 cycles, retry_count 1,2,3...,
//     saturates at 15.
//   3 Glitch in STABLE: drop pll_locked 1 cycle after 5 stable cycles -> state returns to 1,
//     pll_rst stays 0, stable count restarts at 0.
//   4 Lock loss in RUN: drop pll_locked -> sys_reset=1 two to three cycles later, state=0,
//     lock_loss_cnt=1 (0 if LOCK_LOSS_CNT_EN undefined).
//   5 sw_reset_req in RUN and in WAIT_LOCK -> state=0 next edge, pll_rst=1 for 4 cycles,
//     both counters unchanged.
//   6 Async rst pulse mid-STABLE (no clock edge) -> all outputs at reset values immediately.

Source files
------------

// File: rtl/pll_reset_sequencer.sv
// PLL power-up / lock-loss reset sequencer running on the free-running refclk.
// Define LOCK_LOSS_CNT_EN to build the saturating RUN lock-loss counter.
module pll_reset_sequencer #(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 50000,
  parameter int STABLE_CYCLES  = 1024,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       sw_reset_req,
  output logic       pll_rst,
  output logic       sys_reset,
  output logic       ready,
  output logic [1:0] state,
  output logic [3:0] retry_count,
  output logic [7:0] lock_loss_cnt
);

  localparam int MAX_A = (PLL_RST_CYCLES > LOCK_TIMEOUT) ?
                         PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_C = (MAX_A > STABLE_CYCLES) ?
                         MAX_A : STABLE_CYCLES;
  localparam int CW = $clog2(MAX_C + 1);

  localparam logic [CW-1:0] L_RST = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] L_TO  = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] L_STB = CW'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_PLL_RST   = 2'd0,
    S_WAIT_LOCK = 2'd1,
    S_STABLE    = 2'd2,
    S_RUN       = 2'd3
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [CW-1:0]          r_cnt;
  logic [CW-1:0]          w_cnt_next;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_locked_s;
  logic                   w_timeout;
  logic                   r_pll_rst;
  logic                   r_sys_reset;
  logic                   r_ready;
  logic [3:0]             r_retry;

  assign w_locked_s = r_sync[SYNC_STAGES-1];

  always_comb begin
    w_next    = r_state;
    w_timeout = 1'b0;
    if (sw_reset_req) begin
      w_next = S_PLL_RST;
    end else begin
      unique case (r_state)
        S_PLL_RST: begin
          if (r_cnt == L_RST) w_next = S_WAIT_LOCK;
        end
        S_WAIT_LOCK: begin
          if (w_locked_s) begin
            w_next = S_STABLE;
          end else if (r_cnt == L_TO) begin
            w_next    = S_PLL_RST;
            w_timeout = 1'b1;
          end
        end
        S_STABLE: begin
          if (!w_locked_s)          w_next = S_WAIT_LOCK;
          else if (r_cnt == L_STB) w_next = S_RUN;
        end
        S_RUN: begin
          if (!w_locked_s) w_next = S_PLL_RST;
        end
        default: w_next = S_PLL_RST;
      endcase
    end
  end

  // Any (re)entry to a state restarts the shared counter; RUN does not count.
  always_comb begin
    w_cnt_next = r_cnt + 1'b1;
    if (sw_reset_req || (w_next != r_state) || (r_state == S_RUN))
      w_cnt_next = '0;
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      r_sync      <= '0;
      r_state     <= S_PLL_RST;
      r_cnt       <= '0;
      r_pll_rst   <= 1'b1;
      r_sys_reset <= 1'b1;
      r_ready     <= 1'b0;
      r_retry     <= 4'd0;
    end else begin
      r_sync      <= {r_sync[SYNC_STAGES-2:0], pll_locked};
      r_state     <= w_next;
      r_cnt       <= w_cnt_next;
      r_pll_rst   <= (w_next == S_PLL_RST);
      r_sys_reset <= (w_next != S_RUN);
      r_ready     <= (w_next == S_RUN);
      if (w_timeout && (r_retry != 4'hF))
        r_retry <= r_retry + 4'd1;
    end
  end

`ifdef LOCK_LOSS_CNT_EN
  logic [7:0] r_loss_cnt;
  logic       w_loss;

  assign w_loss = (r_state == S_RUN) && !w_locked_s && !sw_reset_req;

  always_ff @(posedge refclk or posedge rst) begin
    if (rst)
      r_loss_cnt <= 8'd0;
    else if (w_loss && (r_loss_cnt != 8'hFF))
      r_loss_cnt <= r_loss_cnt + 8'd1;
  end

  assign lock_loss_cnt = r_loss_cnt;
`else
  assign lock_loss_cnt = 8'd0;
`endif

  assign pll_rst     = r_pll_rst;
  assign sys_reset   = r_sys_reset;
  assign ready       = r_ready;
  assign state       = r_state;
  assign retry_count = r_retry;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed self-checking bench for pll_reset_sequencer with small parameters.
// Expected lock_loss_cnt follows LOCK_LOSS_CNT_EN.
module tb_pll_reset_sequencer;

  logic       refclk = 1'b0;
  logic       rst = 1'b0;
  logic       pll_locked = 1'b0;
  logic       sw_reset_req = 1'b0;
  logic       pll_rst;
  logic       sys_reset;
  logic       ready;
  logic [1:0] state;
  logic [3:0] retry_count;
  logic [7:0] lock_loss_cnt;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_ll;

  pll_reset_sequencer #(
    .PLL_RST_CYCLES(4),
    .LOCK_TIMEOUT(20),
    .STABLE_CYCLES(8),
    .SYNC_STAGES(2)
  ) dut (
    .refclk(refclk),
    .rst(rst),
    .pll_locked(pll_locked),
    .sw_reset_req(sw_reset_req),
    .pll_rst(pll_rst),
    .sys_reset(sys_reset),
    .ready(ready),
    .state(state),
    .retry_count(retry_count),
    .lock_loss_cnt(lock_loss_cnt)
  );

  always #5 refclk = ~refclk;

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  task automatic wait_stable(input string nm);
    int n;
    n = 0;
    while (state !== 2'd2 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (state !== 2'd2) begin
      errors++;
      $display("FAIL %s_wait: state=%0d want 2", nm, state);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #2 rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({pll_rst, sys_reset, ready} !== 3'b110 || state !== 2'd0 ||
        retry_count !== 4'd0 || lock_loss_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset: rst/sys/rdy=%b%b%b st=%0d rc=%0d ll=%0d want 110 0 0 0",
               pll_rst, sys_reset, ready, state, retry_count, lock_loss_cnt);
    end
    rst = 1'b0;
  endtask

  task automatic test_powerup();
    checks++;
    if (pll_rst !== 1'b1 || state !== 2'd0) begin
      errors++;
      $display("FAIL pwr_c0: pll_rst=%b st=%0d want 1 0", pll_rst, state);
    end
    for (int c = 1; c <= 21; c++) begin
      tick();
      if (c <= 3) begin
        checks++;
        if (pll_rst !== 1'b1) begin
          errors++;
          $display("FAIL pwr_pll_rst c%0d: got %b want 1", c, pll_rst);
        end
      end
      if (c == 4) begin
        checks++;
        if (pll_rst !== 1'b0 || state !== 2'd1) begin
          errors++;
          $display("FAIL pwr_wait c4: pll_rst=%b st=%0d want 0 1", pll_rst, state);
        end
      end
      if (c == 10) pll_locked = 1'b1;
      if (c == 13) begin
        checks++;
        if (state !== 2'd2) begin
          errors++;
          $display("FAIL pwr_stable c13: st=%0d want 2", state);
        end
      end
      if (c == 20) begin
        checks++;
        if (sys_reset !== 1'b1 || state !== 2'd2) begin
          errors++;
          $display("FAIL pwr_early c20: sys=%b st=%0d want 1 2", sys_reset, state);
        end
      end
      if (c == 21) begin
        checks++;
        if (sys_reset !== 1'b0 || ready !== 1'b1 || state !== 2'd3) begin
          errors++;
          $display("FAIL pwr_run c21: sys=%b rdy=%b st=%0d want 0 1 3",
                   sys_reset, ready, state);
        end
      end
    end
  endtask

  task automatic test_lock_loss();
    pll_locked = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      tick();
      if (c < 3) begin
        checks++;
        if (sys_reset !== 1'b0 || state !== 2'd3) begin
          errors++;
          $display("FAIL loss_hold c%0d: sys=%b st=%0d want 0 3", c, sys_reset, state);
        end
      end
    end
    checks++;
    if (sys_reset !== 1'b1 || ready !== 1'b0 || state !== 2'd0 ||
        pll_rst !== 1'b1 || lock_loss_cnt !== exp_ll || retry_count !== 4'd0) begin
      errors++;
      $display("FAIL loss_c3: sys=%b rdy=%b st=%0d prst=%b ll=%0d rc=%0d want 1 0 0 1 %0d 0",
               sys_reset, ready, state, pll_rst, lock_loss_cnt, retry_count, exp_ll);
    end
  endtask

  task automatic test_timeout();
    logic [3:0] exp_rc;
    for (int r = 1; r <= 16; r++) begin
      repeat (23) tick();
      checks++;
      if (state !== 2'd1 || pll_rst !== 1'b0) begin
        errors++;
        $display("FAIL to_wait r%0d: st=%0d prst=%b want 1 0", r, state, pll_rst);
      end
      tick();
      exp_rc = (r > 15) ? 4'd15 : 4'(r);
      checks++;
      if (state !== 2'd0 || pll_rst !== 1'b1 || retry_count !== exp_rc) begin
        errors++;
        $display("FAIL to_retry r%0d: st=%0d prst=%b rc=%0d want 0 1 %0d",
                 r, state, pll_rst, retry_count, exp_rc);
      end
    end
    checks++;
    if (lock_loss_cnt !== exp_ll) begin
      errors++;
      $display("FAIL to_ll: got %0d want %0d", lock_loss_cnt, exp_ll);
    end
  endtask

  task automatic test_glitch();
    pll_locked = 1'b1;
    wait_stable("glitch");
    for (int c = 1; c <= 17; c++) begin
      tick();
      if (c == 5) pll_locked = 1'b0;
      if (c == 6) pll_locked = 1'b1;
      if (c == 7 || c == 9 || c == 16) begin
        checks++;
        if (state !== 2'd2 || sys_reset !== 1'b1) begin
          errors++;
          $display("FAIL glitch_stable c%0d: st=%0d sys=%b want 2 1", c, state, sys_reset);
        end
      end
      if (c == 8) begin
        checks++;
        if (state !== 2'd1 || pll_rst !== 1'b0 || retry_count !== 4'd15) begin
          errors++;
          $display("FAIL glitch_drop c8: st=%0d prst=%b rc=%0d want 1 0 15",
                   state, pll_rst, retry_count);
        end
      end
      if (c == 17) begin
        checks++;
        if (state !== 2'd3 || sys_reset !== 1'b0) begin
          errors++;
          $display("FAIL glitch_run c17: st=%0d sys=%b want 3 0", state, sys_reset);
        end
      end
    end
  endtask

  task automatic test_sw_reset();
    sw_reset_req = 1'b1;
    tick();
    sw_reset_req = 1'b0;
    checks++;
    if (state !== 2'd0 || pll_rst !== 1'b1 || sys_reset !== 1'b1 || ready !== 1'b0 ||
        retry_count !== 4'd15 || lock_loss_cnt !== exp_ll) begin
      errors++;
      $display("FAIL sw_run: st=%0d prst=%b sys=%b rdy=%b rc=%0d ll=%0d want 0 1 1 0 15 %0d",
               state, pll_rst, sys_reset, ready, retry_count, lock_loss_cnt, exp_ll);
    end
    pll_locked = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c <= 3) begin
        checks++;
        if (pll_rst !== 1'b1) begin
          errors++;
          $display("FAIL sw_run_prst c%0d: got %b want 1", c, pll_rst);
        end
      end
      if (c >= 4) begin
        checks++;
        if (state !== 2'd1 || pll_rst !== 1'b0) begin
          errors++;
          $display("FAIL sw_run_wait c%0d: st=%0d prst=%b want 1 0", c, state, pll_rst);
        end
      end
    end
    sw_reset_req = 1'b1;
    tick();
    sw_reset_req = 1'b0;
    checks++;
    if (state !== 2'd0 || pll_rst !== 1'b1 ||
        retry_count !== 4'd15 || lock_loss_cnt !== exp_ll) begin
      errors++;
      $display("FAIL sw_wait: st=%0d prst=%b rc=%0d ll=%0d want 0 1 15 %0d",
               state, pll_rst, retry_count, lock_loss_cnt, exp_ll);
    end
    for (int c = 1; c <= 4; c++) begin
      tick();
      checks++;
      if (pll_rst !== (c <= 3)) begin
        errors++;
        $display("FAIL sw_wait_prst c%0d: got %b want %b", c, pll_rst, c <= 3);
      end
    end
  endtask

  task automatic test_async_rst();
    pll_locked = 1'b1;
    wait_stable("arst");
    tick();
    tick();
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({pll_rst, sys_reset, ready} !== 3'b110 || state !== 2'd0 ||
        retry_count !== 4'd0 || lock_loss_cnt !== 8'd0) begin
      errors++;
      $display("FAIL arst: rst/sys/rdy=%b%b%b st=%0d rc=%0d ll=%0d want 110 0 0 0",
               pll_rst, sys_reset, ready, state, retry_count, lock_loss_cnt);
    end
    tick();
    rst = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c == 3) begin
        checks++;
        if (state !== 2'd0 || pll_rst !== 1'b1) begin
          errors++;
          $display("FAIL arst_restart c3: st=%0d prst=%b want 0 1", state, pll_rst);
        end
      end
      if (c == 4) begin
        checks++;
        if (state !== 2'd1) begin
          errors++;
          $display("FAIL arst_wait c4: st=%0d want 1", state);
        end
      end
      if (c == 5) begin
        checks++;
        if (state !== 2'd2) begin
          errors++;
          $display("FAIL arst_stable c5: st=%0d want 2", state);
        end
      end
    end
  endtask

  initial begin
`ifdef LOCK_LOSS_CNT_EN
    exp_ll = 8'd1;
`else
    exp_ll = 8'd0;
`endif
    test_reset();
    test_powerup();
    test_lock_loss();
    test_timeout();
    test_glitch();
    test_sw_reset();
    test_async_rst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
